// File: rtl/csh_pkg.sv
// csh_pkg: shared types, constants and helpers for the cache refill path
package csh_pkg;
  localparam int WORDS_PER_LINE = 4;
  localparam int NWAYS = 4;
  localparam int WD_W = $clog2(WORDS_PER_LINE);
  localparam int WAY_W = $clog2(NWAYS);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD} csh_refill_state_t;
  function automatic logic [NWAYS-1:0] way_sel_l(input logic [WAY_W-1:0] way);
    return ~(NWAYS'(1) << way);
  endfunction
endpackage

// File: rtl/csh_par_gen.sv
// csh_par_gen: odd-parity generator, shared with the cache read-check path
module csh_par_gen #(
  parameter int W = 36
) (
  input  logic [W-1:0] data_i,
  output logic         par_o
);
  assign par_o = ~^data_i;
endmodule

// File: rtl/csh_refill_seq.sv
// csh_refill_seq: writes a wrap-ordered 4-word memory line into the cache data slices
// with a setup/strobe/hold write pulse per word
module csh_refill_seq
  import csh_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int IDX_W = 7
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  refill_start_h,
  input  logic [WAY_W-1:0]      refill_way_h,
  input  logic [IDX_W-1:0]      refill_idx_h,
  input  logic [WD_W-1:0]       refill_first_wd_h,
  input  logic [DATA_W-1:0]     mem_data_h,
  input  logic                  mem_data_valid_h,
  input  logic                  mem_error_h,
  output logic                  mem_data_rdy_h,
  output logic [DATA_W-1:0]     mem_to_cache_h,
  output logic                  csh_par_bit_in_h,
  output logic [IDX_W+WD_W-1:0] cache_adr_h,
  output logic [NWAYS-1:0]      csh_sel_l,
  output logic                  cache_wr_l,
  output logic                  refill_busy_h,
  output logic                  first_wd_wr_h,
  output logic                  refill_done_h,
  output logic                  refill_abort_h
);
  csh_refill_state_t state_q;
  logic [WAY_W-1:0] way_q;
  logic [IDX_W-1:0] idx_q;
  logic [WD_W-1:0] first_q, cnt_q, word_d;
  logic [DATA_W-1:0] data_q;
  logic par_q, par_d, last;
  logic [IDX_W+WD_W-1:0] adr_q;
  logic [NWAYS-1:0] sel_q;
  csh_par_gen #(.W(DATA_W)) u_par (.data_i(mem_data_h), .par_o(par_d));
  assign word_d = first_q + cnt_q;
  assign last = cnt_q == WD_W'(WORDS_PER_LINE - 1);
  assign mem_data_rdy_h = state_q == S_WAIT;
  assign mem_to_cache_h = data_q;
  assign csh_par_bit_in_h = par_q;
  assign cache_adr_h = adr_q;
  assign csh_sel_l = sel_q;
  assign cache_wr_l = state_q != S_STROBE;
  assign refill_busy_h = state_q != S_IDLE;
  assign first_wd_wr_h = state_q == S_HOLD && cnt_q == '0;
  assign refill_done_h = state_q == S_HOLD && last;
  // an errored word is dropped in the same cycle it is offered
  assign refill_abort_h = mem_data_rdy_h && mem_data_valid_h && mem_error_h;
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      way_q <= '0;
      idx_q <= '0;
      first_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      par_q <= 1'b1;
      adr_q <= '0;
      sel_q <= '1;
    end else begin
      case (state_q)
        S_IDLE: if (refill_start_h) begin
          way_q <= refill_way_h;
          idx_q <= refill_idx_h;
          first_q <= refill_first_wd_h;
          cnt_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (mem_data_valid_h) begin
          if (mem_error_h) begin
            state_q <= S_IDLE;
            sel_q <= '1;
          end else begin
            data_q <= mem_data_h;
            par_q <= par_d;
            adr_q <= {idx_q, word_d};
            sel_q <= way_sel_l(way_q);
            state_q <= S_SETUP;
          end
        end
        S_SETUP: state_q <= S_STROBE;
        S_STROBE: state_q <= S_HOLD;
        S_HOLD: begin
          state_q <= last ? S_IDLE : S_WAIT;
          cnt_q <= cnt_q + WD_W'(1);
          if (last) sel_q <= '1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/csh_refill_seq.md
Name: csh_refill_seq

Overview:
- Cache refill write sequencer that feeds the cache data-slice RAMs.
- Accepts a 4-word line from memory over a valid/ready handshake, in requested-word-first wrap order.
- For each word it drives the 36-bit memory-to-cache data, the generated parity bit, the cache word address, the active-low one-hot way select, and a setup/strobe/hold write pulse.
- Sits between the MBox memory-return path and the per-bit-slice cache data boards.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; must be a power of 2.
- NWAYS, 4, cache ways; one select line per way.
- DATA_W, 36, data word width.
- IDX_W, 7, line-index width (cache address bits 27..33).

Ports:
- clk  input  1  system clock.
- reset_l  input  1  synchronous, active-low reset.
- refill_start_h  input  1  one-cycle request to begin a line refill; honoured only in IDLE.
- refill_way_h  input  2  victim way, captured on start.
- refill_idx_h  input  IDX_W  line index, captured on start.
- refill_first_wd_h  input  2  first (requested) word within the line, captured on start.
- mem_data_h  input  DATA_W  returning memory word.
- mem_data_valid_h  input  1  mem_data_h is valid.
- mem_error_h  input  1  memory error or NXM for the current word.
- mem_data_rdy_h  output  1  sequencer can accept a word this cycle.
- mem_to_cache_h  output  DATA_W  write data to the cache slices.
- csh_par_bit_in_h  output  1  odd parity over mem_to_cache_h.
- cache_adr_h  output  IDX_W+2  cache address {idx, word}; word occupies bits 34..35.
- csh_sel_l  output  NWAYS  active-low one-hot way select.
- cache_wr_l  output  1  active-low write strobe.
- refill_busy_h  output  1  refill in progress.
- first_wd_wr_h  output  1  one-cycle pulse: requested word written (early restart).
- refill_done_h  output  1  one-cycle pulse: all words written.
- refill_abort_h  output  1  one-cycle pulse: refill abandoned on error.

Behaviour:
- Reset is synchronous: reset_l=0 at an edge forces IDLE. Values after reset:
  - mem_to_cache_h=0, csh_par_bit_in_h=1 (odd parity of 0), cache_adr_h=0.
  - csh_sel_l=all ones, cache_wr_l=1.
  - mem_data_rdy_h=0, refill_busy_h=0, all pulses 0.
  - Reset mid-write abandons the line with no abort pulse.
- States: IDLE, WAIT, SETUP, STROBE, HOLD.
- IDLE:
  - refill_start_h=1 captures way, idx and first_wd; word counter=0; go to WAIT.
  - refill_busy_h goes high the next cycle.
- WAIT:
  - mem_data_rdy_h=1, asserted only in WAIT.
  - On valid&rdy with mem_error_h=0: register the data and the parity, set cache_adr_h={idx, first_wd+count mod 4}, drive the selected way's csh_sel_l low, go to SETUP.
  - On valid&rdy with mem_error_h=1: pulse refill_abort_h, go to IDLE, issue no write.
  - mem_error_h without valid is ignored.
- SETUP: data, address and select stable; cache_wr_l=1.
- STROBE: cache_wr_l=0 for exactly 1 cycle.
- HOLD:
  - cache_wr_l=1; data, address and select remain driven.
  - If count==0, pulse first_wd_wr_h.
  - If count==WORDS_PER_LINE-1: pulse refill_done_h, go to IDLE, release selects (all ones).
  - Otherwise count++ and go to WAIT.
- Timing: minimum 4 cycles per word (WAIT accept, SETUP, STROBE, HOLD); full line in at least 16 cycles.
- Word order wraps modulo 4, e.g. first_wd=2 gives word addresses 2,3,0,1.
- Parity: csh_par_bit_in_h = ~^mem_to_cache_h, so the 37 bits together hold an odd number of ones. It is registered with the data.
- Outputs are held, not zeroed, between words.
- refill_start_h while busy is ignored; it is not queued.
- refill_done_h and refill_abort_h are mutually exclusive.
- refill_busy_h falls in the cycle after done or abort.

Decomposition:
- Package csh_pkg:
  - csh_refill_state_t enum.
  - WORDS_PER_LINE and NWAYS constants.
  - way_sel_l(way) function returning the active-low one-hot select.
- Sub-module csh_par_gen: combinational 36-bit odd-parity tree, reusable by the cache read-check logic.

Test Plan:
- Basic refill: start with way=1, idx=7'h15, first_wd=0; words 36'h0, 36'h1, 36'h3, 36'h7FFFFFFFF supplied back-to-back.
  - Exactly 4 cache_wr_l low pulses, 4 cycles apart.
  - Addresses 0x54, 0x55, 0x56, 0x57.
  - csh_sel_l=4'b1101 throughout; parity bits 1, 0, 1, 0.
  - first_wd_wr_h on word 0; refill_done_h after word 3.
- Wrap order: first_wd=3, idx=0 -> word addresses 3, 0, 1, 2; first_wd_wr_h in the HOLD cycle of the word at address 3.
- Stalled memory: mem_data_valid_h low for 5 cycles between each word -> mem_data_rdy_h stays high throughout WAIT; no strobe until valid; data latched only on the handshake.
- Error abort: mem_error_h with valid on the second word -> refill_abort_h pulses; only 1 write strobe issued; no refill_done_h; csh_sel_l returns to 4'b1111.
- Reset during STROBE: reset_l=0 -> next cycle cache_wr_l=1, csh_sel_l=4'b1111, busy=0; a new start afterwards refills normally.
- Start while busy: refill_start_h pulses during the word-2 WAIT -> ignored; captured way and index unchanged; only 4 strobes total.
